// File: rtl/dro_pkg.sv
// Shared definitions for the DRO channel bank.
//   dro_state_e : per-channel storage state (EMPTY, SET, AMBIG)
//   DEF_*       : default timing/size constants used as parameter defaults
//   cnt_width() : bits needed to hold a counter that saturates at max_val
package dro_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SET   = 2'd1,
    AMBIG = 2'd2
  } dro_state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_SETUP = 3;
  localparam int DEF_DELAY   = 4;
  localparam int DEF_PULSE_W = 2;
  localparam int DEF_CNT_W   = 16;

  // Width of a counter running 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dro_channel.sv
// One destructive-readout cell with timing checks and a delayed, stretched readout.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   d          : one-cycle data pulse for this channel
//   clk_pulse  : shared readout strobe
//   hold_open  : high while a d pulse would fall inside the hold window
//   out_pulse  : clean '1' readout, DELAY cycles after the strobe, PULSE_W wide
//   out_err    : ambiguous readout (setup or hold problem), same timing
//   viol_flag  : combinational, this channel violated setup or hold this cycle
module dro_channel
  import dro_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int DELAY   = DEF_DELAY,
  parameter int PULSE_W = DEF_PULSE_W
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic clk_pulse,
  input  logic hold_open,
  output logic out_pulse,
  output logic out_err,
  output logic viol_flag
);

  localparam int AGE_W = cnt_width(T_SETUP);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(T_SETUP);
  localparam int STR_W = cnt_width(PULSE_W - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(PULSE_W - 1);

  dro_state_e       state_reg;
  logic [AGE_W-1:0] age_reg;

  logic launch_val;
  logic launch_err;
  logic setup_viol;
  logic hold_viol;

  // Readout decision and violation detection for the current cycle.
  always_comb begin
    launch_val = 1'b0;
    launch_err = 1'b0;
    setup_viol = 1'b0;
    hold_viol  = 1'b0;
    if (clk_pulse) begin
      // A d pulse coincident with the strobe is always a setup failure.
      if (d)
        setup_viol = 1'b1;
      else if (state_reg == SET && age_reg < AGE_MAX)
        setup_viol = 1'b1;
      launch_err = setup_viol || (state_reg == AMBIG);
      launch_val = (state_reg == SET) && !launch_err;
    end else if (d && hold_open) begin
      hold_viol = 1'b1;
    end
  end

  assign viol_flag = setup_viol | hold_viol;

  // Storage state: the strobe always empties the cell and consumes any
  // coincident d pulse; age only runs while SET and saturates at T_SETUP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      age_reg   <= '0;
    end else if (clk_pulse) begin
      state_reg <= EMPTY;
      age_reg   <= '0;
    end else begin
      if (d) begin
        if (hold_open) begin
          state_reg <= AMBIG;
        end else if (state_reg == EMPTY) begin
          state_reg <= SET;
          age_reg   <= '0;
        end
      end
      if (state_reg == SET && age_reg != AGE_MAX)
        age_reg <= age_reg + 1'b1;
    end
  end

  // Stretch is applied before the delay line: the waveform entering the
  // pipe is already PULSE_W wide, so the pipe is a plain shift register.
  // A new launch reloads the stretch, replacing whatever was being held.
  logic [1:0]       held_reg;   // {err, val}
  logic [STR_W-1:0] str_cnt_reg;
  logic [1:0]       stretch_now;

  always_comb begin
    stretch_now = 2'b00;
    if (launch_val || launch_err)
      stretch_now = {launch_err, launch_val};
    else if (str_cnt_reg != '0)
      stretch_now = held_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_reg    <= 2'b00;
      str_cnt_reg <= '0;
    end else if (launch_val || launch_err) begin
      held_reg    <= {launch_err, launch_val};
      str_cnt_reg <= STR_LOAD;
    end else if (str_cnt_reg != '0) begin
      str_cnt_reg <= str_cnt_reg - 1'b1;
    end
  end

  // DELAY-deep shift register of {err, val}; its last stage is the output.
  logic [1:0] pipe_reg [DELAY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DELAY; k++)
        pipe_reg[k] <= 2'b00;
    end else begin
      pipe_reg[0] <= stretch_now;
      for (int k = 1; k < DELAY; k++)
        pipe_reg[k] <= pipe_reg[k-1];
    end
  end

  assign out_pulse = pipe_reg[DELAY-1][0];
  assign out_err   = pipe_reg[DELAY-1][1];

endmodule

// File: rtl/dro_array.sv
// WIDTH-channel bank of RSFQ destructive-readout cells on a shared SFQ clock.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   d_pulse    : one-cycle data pulses, one bit per channel
//   clk_pulse  : one-cycle readout strobe shared by all channels
//   out_pulse  : per-channel clean '1' readout pulses
//   out_err    : per-channel ambiguous readout pulses
//   viol       : one-cycle strobe, a violation was detected the previous cycle
//   viol_count : saturating count of violating channel events
module dro_array
  import dro_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int DELAY   = DEF_DELAY,
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_pulse,
  input  logic             clk_pulse,
  output logic [WIDTH-1:0] out_pulse,
  output logic [WIDTH-1:0] out_err,
  output logic             viol,
  output logic [CNT_W-1:0] viol_count
);

  // since_clk_reg holds (cycles since the last strobe) - 1 as seen at the
  // current edge, so a d pulse arriving k cycles after the strobe is a hold
  // violation when k < T_HOLD. T_HOLD of 0 or 1 never opens the window.
  localparam int SC_W = cnt_width(T_HOLD);
  localparam logic [SC_W-1:0] SC_MAX   = SC_W'(T_HOLD);
  localparam logic [SC_W-1:0] HOLD_LIM = SC_W'((T_HOLD > 1) ? (T_HOLD - 1) : 0);

  localparam int PC_W  = cnt_width(WIDTH);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_SAT = SUM_W'({CNT_W{1'b1}});

  logic [SC_W-1:0]  since_clk_reg;
  logic             hold_open;
  logic [WIDTH-1:0] viol_flag;
  logic [PC_W-1:0]  viol_pop;
  logic [SUM_W-1:0] cnt_sum;
  logic             viol_reg;
  logic [CNT_W-1:0] viol_count_reg;

  always_ff @(posedge clk) begin
    if (rst)
      since_clk_reg <= SC_MAX;
    else if (clk_pulse)
      since_clk_reg <= '0;
    else if (since_clk_reg != SC_MAX)
      since_clk_reg <= since_clk_reg + 1'b1;
  end

  assign hold_open = (since_clk_reg < HOLD_LIM);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    dro_channel #(
      .T_SETUP (T_SETUP),
      .DELAY   (DELAY),
      .PULSE_W (PULSE_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .d         (d_pulse[gi]),
      .clk_pulse (clk_pulse),
      .hold_open (hold_open),
      .out_pulse (out_pulse[gi]),
      .out_err   (out_err[gi]),
      .viol_flag (viol_flag[gi])
    );
  end

  always_comb begin
    viol_pop = '0;
    for (int k = 0; k < WIDTH; k++)
      viol_pop = viol_pop + PC_W'(viol_flag[k]);
  end

  // Sum computed one bit wider than either operand so saturation is exact.
  assign cnt_sum = SUM_W'(viol_count_reg) + SUM_W'(viol_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      viol_reg       <= 1'b0;
      viol_count_reg <= '0;
    end else begin
      viol_reg <= |viol_flag;
      if (cnt_sum > CNT_SAT)
        viol_count_reg <= {CNT_W{1'b1}};
      else
        viol_count_reg <= cnt_sum[CNT_W-1:0];
    end
  end

  assign viol       = viol_reg;
  assign viol_count = viol_count_reg;

endmodule

// File: tb/tb_dro_array.sv
// Directed-vector bench for dro_array. Each test fills per-cycle stimulus and
// expectation tables (relative cycle k: outputs observed, then inputs driven,
// then the edge that samples them) and replays them against two instances:
// the default configuration and a CNT_W=2 copy for counter saturation.
module tb_dro_array;

  localparam int W   = 8;
  localparam int LEN = 80;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d_pulse = '0;
  logic         clk_pulse = 1'b0;

  logic [W-1:0] out_pulse, out_err, out_pulse_s, out_err_s;
  logic         viol, viol_s;
  logic [15:0]  viol_count;
  logic [1:0]   viol_count_s;

  dro_array #(
    .WIDTH(W), .T_HOLD(2), .T_SETUP(3), .DELAY(4), .PULSE_W(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .d_pulse(d_pulse), .clk_pulse(clk_pulse),
    .out_pulse(out_pulse), .out_err(out_err), .viol(viol), .viol_count(viol_count)
  );

  dro_array #(
    .WIDTH(W), .T_HOLD(2), .T_SETUP(3), .DELAY(4), .PULSE_W(2), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .d_pulse(d_pulse), .clk_pulse(clk_pulse),
    .out_pulse(out_pulse_s), .out_err(out_err_s), .viol(viol_s), .viol_count(viol_count_s)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] d_tab  [LEN];
  logic         ck_tab [LEN];
  logic         rst_tab[LEN];
  logic [W-1:0] ep_tab [LEN];
  logic [W-1:0] ee_tab [LEN];
  logic         ev_tab [LEN];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_tab();
    for (int k = 0; k < LEN; k++) begin
      d_tab[k]   = '0;
      ck_tab[k]  = 1'b0;
      rst_tab[k] = 1'b0;
      ep_tab[k]  = '0;
      ee_tab[k]  = '0;
      ev_tab[k]  = 1'b0;
    end
  endtask

  task automatic run_tab(input string name, input int len, input int exp_cnt, input int exp_cnt_s);
    for (int k = 0; k < len; k++) begin
      check_val($sformatf("%s c%0d out_pulse", name, k), 32'(out_pulse), 32'(ep_tab[k]));
      check_val($sformatf("%s c%0d out_err", name, k), 32'(out_err), 32'(ee_tab[k]));
      check_val($sformatf("%s c%0d viol", name, k), 32'(viol), 32'(ev_tab[k]));
      rst       = rst_tab[k];
      d_pulse   = d_tab[k];
      clk_pulse = ck_tab[k];
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    d_pulse   = '0;
    clk_pulse = 1'b0;
    check_val($sformatf("%s viol_count", name), 32'(viol_count), 32'(exp_cnt));
    check_val($sformatf("%s viol_count_sat", name), 32'(viol_count_s), 32'(exp_cnt_s));
    $display("%s: %0d cycles, viol_count=%0d, sat viol_count=%0d", name, len, viol_count, viol_count_s);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;

    // T1: reset held 3 cycles with every input asserted, then a clean read
    // straight after release (hold window must start closed).
    clear_tab();
    for (int k = 0; k < 3; k++) begin
      rst_tab[k] = 1'b1;
      d_tab[k]   = 8'hFF;
      ck_tab[k]  = 1'b1;
    end
    d_tab[3]  = 8'h02;
    ck_tab[8] = 1'b1;
    ep_tab[12] = 8'h02;
    ep_tab[13] = 8'h02;
    run_tab("t1_reset", 18, 0, 0);

    // T2: clean read, d at 10, strobe at 20 -> pulse 24..25.
    clear_tab();
    d_tab[10]  = 8'h01;
    ck_tab[20] = 1'b1;
    ep_tab[24] = 8'h01;
    ep_tab[25] = 8'h01;
    run_tab("t2_clean", 30, 0, 0);

    // T3: setup violation (age 1 < 3), then d coincident with the strobe.
    clear_tab();
    d_tab[10]  = 8'h08;
    ck_tab[12] = 1'b1;
    ev_tab[13] = 1'b1;
    ee_tab[16] = 8'h08;
    ee_tab[17] = 8'h08;
    d_tab[30]  = 8'h08;
    ck_tab[30] = 1'b1;
    ev_tab[31] = 1'b1;
    ee_tab[34] = 8'h08;
    ee_tab[35] = 8'h08;
    run_tab("t3_setup", 40, 2, 2);

    // T4: hold violation one cycle after the strobe; two cycles after is clean.
    clear_tab();
    ck_tab[10] = 1'b1;
    d_tab[11]  = 8'h20;
    ev_tab[12] = 1'b1;
    ck_tab[30] = 1'b1;
    ee_tab[34] = 8'h20;
    ee_tab[35] = 8'h20;
    ck_tab[40] = 1'b1;
    d_tab[42]  = 8'h20;
    ck_tab[50] = 1'b1;
    ep_tab[54] = 8'h20;
    ep_tab[55] = 8'h20;
    run_tab("t4_hold", 60, 3, 3);

    // T5: several channels read at once; the second strobe finds them empty.
    clear_tab();
    d_tab[5]   = 8'hA5;
    ck_tab[15] = 1'b1;
    ck_tab[16] = 1'b1;
    ep_tab[19] = 8'hA5;
    ep_tab[20] = 8'hA5;
    run_tab("t5_multi", 30, 3, 3);

    // Back-to-back strobes: a later err restarts the stretch over a '1'.
    clear_tab();
    d_tab[0]   = 8'h04;
    ck_tab[5]  = 1'b1;
    d_tab[6]   = 8'h04;
    ck_tab[6]  = 1'b1;
    ev_tab[7]  = 1'b1;
    ep_tab[9]  = 8'h04;
    ee_tab[10] = 8'h04;
    ee_tab[11] = 8'h04;
    run_tab("t_override", 20, 4, 3);

    // T6: three setup-violating reads of two channels; 2-bit counter sticks at 3.
    clear_tab();
    for (int r = 0; r < 3; r++) begin
      d_tab[3*r]         = 8'h03;
      ck_tab[3*r+1]      = 1'b1;
      ev_tab[3*r+2]      = 1'b1;
      ee_tab[3*r+5]      = 8'h03;
      ee_tab[3*r+6]      = 8'h03;
    end
    run_tab("t6_sat", 20, 10, 3);

    // Reset while a readout pulse is high truncates it the next cycle.
    clear_tab();
    d_tab[0]   = 8'h10;
    ck_tab[5]  = 1'b1;
    ep_tab[9]  = 8'h10;
    rst_tab[9] = 1'b1;
    run_tab("t6_rst_mid", 16, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
